ahb_dec_mux: RTL and testbench

Parametrised AHB-Lite address decoder and slave-response multiplexer for the system interconnect. It decodes HADDR into a one-hot HSEL across NSLV programmable address regions. It registers the data-phase selection and muxes HRDATA/HREADYOUT/HRESP back to the master. Unmapped addresses go to a built-in default slave, which returns the two-cycle AHB ERROR response and counts decode errors.

---
 rtl/ahb_dec_mux.sv | 129 ++++++++++++
 tb/tb_ahb_dec_mux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dec_mux.sv
// AHB-Lite address decoder and response mux
// with a built-in default slave for unmapped space.
module ahb_dec_mux #(
  parameter int NSLV = 3,
  parameter int DW = 32,
  parameter logic [NSLV*32-1:0] REGION_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] REGION_MASK =
    {32'hE000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int ERRCNT_W = 16
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic [31:0]         haddr,
  input  logic [1:0]          htrans,
  output logic [NSLV-1:0]     hsel,
  input  logic [NSLV-1:0]     hreadyout_s,
  input  logic [NSLV-1:0]     hresp_s,
  input  logic [NSLV*DW-1:0]  hrdata_s,
  output logic                hready,
  output logic                hresp,
  output logic [DW-1:0]       hrdata,
  output logic                dec_err,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } dflt_st_e;

  dflt_st_e      st;
  dflt_st_e      st_nxt;
  logic [NSLV:0] dp_sel;
  logic          dflt;
  logic          hit;
  logic          err_go;
  logic          d_ready;
  logic          d_resp;

  // Priority region decode; lowest matching slot wins.
  always_comb begin
    hsel = '0;
    hit  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit &&
          ((haddr & REGION_MASK[32*i +: 32]) ==
           (REGION_BASE[32*i +: 32] &
            REGION_MASK[32*i +: 32]))) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  assign dflt   = ~|hsel;
  assign err_go = hready & dflt & htrans[1];

  // Data-phase select; all-zero means no transfer yet.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_sel <= '0;
    end else if (hready) begin
      dp_sel <= {dflt, hsel};
    end
  end

  // Response mux driven by the data-phase owner.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dp_sel[i]) begin
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
        hrdata = hrdata_s[i*DW +: DW];
      end
    end
    if (dp_sel[NSLV]) begin
      hready = d_ready;
      hresp  = d_resp;
    end
  end

  // Default-slave state register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      st <= S_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Default-slave two-cycle ERROR sequencing.
  always_comb begin
    st_nxt  = st;
    d_ready = 1'b1;
    d_resp  = 1'b0;
    dec_err = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (err_go) st_nxt = S_ERR1;
      end
      S_ERR1: begin
        d_ready = 1'b0;
        d_resp  = 1'b1;
        dec_err = 1'b1;
        st_nxt  = S_ERR2;
      end
      S_ERR2: begin
        d_resp = 1'b1;
        st_nxt = err_go ? S_ERR1 : S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // Saturating count of default-slave errors.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_count <= '0;
    end else if (st == S_ERR1 && err_count != '1) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ahb_dec_mux.sv
// Scoreboard bench for ahb_dec_mux: default map
// plus an overlapping map with a 2-bit counter.
module tb_ahb_dec_mux;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  ro = 3'b111;
  logic [2:0]  rs = '0;
  logic [95:0] rd = '0;

  logic [2:0]  hsel, hsel2;
  logic        hready, hready2;
  logic        hresp, hresp2;
  logic [31:0] hrdata, hrdata2;
  logic        dec_err, dec_err2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  localparam logic [95:0] RD_FIX =
    {32'h2222_0000, 32'hCAFE_F00D, 32'h1111_0000};

  always #5 hclk = ~hclk;

  ahb_dec_mux dut (
    .hclk(hclk), .hreset(hreset),
    .haddr(haddr), .htrans(htrans),
    .hsel(hsel), .hreadyout_s(ro),
    .hresp_s(rs), .hrdata_s(rd),
    .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .dec_err(dec_err),
    .err_count(cnt)
  );

  ahb_dec_mux #(
    .REGION_BASE({32'h2000_0000, 32'h0000_0000,
                  32'h0000_0000}),
    .REGION_MASK({32'hE000_0000, 32'hE000_0000,
                  32'hF000_0000}),
    .ERRCNT_W(2)
  ) dut2 (
    .hclk(hclk), .hreset(hreset),
    .haddr(haddr), .htrans(htrans),
    .hsel(hsel2), .hreadyout_s(ro),
    .hresp_s(rs), .hrdata_s(rd),
    .hready(hready2), .hresp(hresp2),
    .hrdata(hrdata2), .dec_err(dec_err2),
    .err_count(cnt2)
  );

  typedef struct {
    string       nm;
    int          sel;
    bit          rdy;
    bit          rsp;
    logic [31:0] rdata;
    bit          dec;
    int          cnt;
    int          sel2;
    int          cnt2;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(string nm, string f,
                     longint act, longint req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s.%s actual=%0h required=%0h",
               nm, f, act, req);
    end
  endtask

  // Monitor: pops one expectation per presented cycle.
  always @(negedge hclk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "hready", hready, e.rdy);
      chk(e.nm, "hresp", hresp, e.rsp);
      chk(e.nm, "hrdata", hrdata, e.rdata);
      chk(e.nm, "dec_err", dec_err, e.dec);
      if (e.sel >= 0) chk(e.nm, "hsel", hsel, e.sel);
      if (e.cnt >= 0) chk(e.nm, "err_count", cnt, e.cnt);
      if (e.sel2 >= 0) chk(e.nm, "hsel2", hsel2, e.sel2);
      if (e.cnt2 >= 0) chk(e.nm, "err_count2", cnt2, e.cnt2);
    end
  end

  task automatic drv(logic r, logic [31:0] a,
                     logic [1:0] t, logic [2:0] o,
                     logic [2:0] s);
    @(posedge hclk);
    #1;
    hreset = r;
    haddr  = a;
    htrans = t;
    ro     = o;
    rs     = s;
    rd     = RD_FIX;
  endtask

  task automatic ex(string nm, int sel, bit rdy, bit rsp,
                    logic [31:0] rdata, bit dec, int c,
                    int sel2 = -1, int c2 = -1);
    exp_t e;
    e.nm = nm; e.sel = sel; e.rdy = rdy; e.rsp = rsp;
    e.rdata = rdata; e.dec = dec; e.cnt = c;
    e.sel2 = sel2; e.cnt2 = c2;
    q.push_back(e);
  endtask

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;

  initial begin
    int guard;
    for (int k = 0; k < 2; k++) begin
      @(posedge hclk);
      #1;
      haddr  = $urandom;
      htrans = 2'($urandom_range(0, 3));
      ro     = 3'($urandom_range(0, 7));
      rs     = 3'($urandom_range(0, 7));
      rd     = {$urandom, $urandom, $urandom};
      ex("reset", -1, 1, 0, 0, 0, 0, -1, 0);
    end
    drv(0, 32'h0000_0010, IDL, 3'b111, 0);
    ex("map0", 3'b001, 1, 0, 0, 0, 0, 3'b001);
    drv(0, 32'h1FFF_FFFC, IDL, 3'b111, 0);
    ex("map1", 3'b010, 1, 0, 32'h1111_0000, 0, 0, 3'b010);
    drv(0, 32'h3000_0000, IDL, 3'b111, 0);
    ex("map2", 3'b100, 1, 0, 32'hCAFE_F00D, 0, 0, 3'b100);
    drv(0, 32'h4000_0000, IDL, 3'b111, 0);
    ex("map_none", 3'b000, 1, 0, 32'h2222_0000, 0, 0, 3'b000);
    drv(0, 32'h4000_0000, IDL, 3'b111, 0);
    ex("dflt_idle", 3'b000, 1, 0, 0, 0, 0);
    drv(0, 32'h1000_0000, NSQ, 3'b111, 0);
    ex("rd_addr", 3'b010, 1, 0, 0, 0, 0);
    drv(0, 32'h8000_0000, NSQ, 3'b101, 0);
    ex("rd_wait1", 3'b000, 0, 0, 32'hCAFE_F00D, 0, 0);
    drv(0, 32'h8000_0000, NSQ, 3'b101, 0);
    ex("rd_wait2", -1, 0, 0, 32'hCAFE_F00D, 0, 0);
    drv(0, 32'h0000_0000, IDL, 3'b111, 0);
    ex("rd_data", 3'b001, 1, 0, 32'hCAFE_F00D, 0, 0);
    drv(0, 32'h8000_0000, NSQ, 3'b111, 0);
    ex("no_capture", 3'b000, 1, 0, 32'h1111_0000, 0, 0);
    drv(0, 32'h0000_0000, IDL, 3'b111, 0);
    ex("unmap_err1", -1, 0, 1, 0, 1, 0);
    drv(0, 32'h0000_0000, IDL, 3'b111, 0);
    ex("unmap_err2", -1, 1, 1, 0, 0, 1);
    drv(0, 32'h9000_0000, NSQ, 3'b111, 0);
    ex("unmap_done", -1, 1, 0, 32'h1111_0000, 0, 1);
    drv(0, 32'h9000_0000, NSQ, 3'b111, 0);
    ex("b2b_a_err1", -1, 0, 1, 0, 1, 1);
    drv(0, 32'h9000_0000, NSQ, 3'b111, 0);
    ex("b2b_a_err2", -1, 1, 1, 0, 0, 2);
    drv(0, 32'h9000_0000, NSQ, 3'b111, 0);
    ex("b2b_b_err1", -1, 0, 1, 0, 1, 2);
    drv(0, 32'h9000_0000, NSQ, 3'b111, 0);
    ex("b2b_b_err2", -1, 1, 1, 0, 0, 3, -1, 3);
    drv(0, 32'h9000_0000, NSQ, 3'b111, 0);
    ex("b2b_c_err1", -1, 0, 1, 0, 1, 3);
    drv(0, 32'h9000_0000, IDL, 3'b111, 0);
    ex("b2b_c_err2", -1, 1, 1, 0, 0, 4, -1, 3);
    drv(0, 32'h9000_0000, IDL, 3'b111, 0);
    ex("idle_unmap1", -1, 1, 0, 0, 0, 4);
    drv(0, 32'hA000_0000, NSQ, 3'b111, 0);
    ex("idle_unmap2", 3'b000, 1, 0, 0, 0, 4, 3'b000);
    drv(0, 32'h0000_0000, IDL, 3'b111, 0);
    ex("sat_err1", -1, 0, 1, 0, 1, 4, -1, 3);
    drv(0, 32'h0000_0000, IDL, 3'b111, 0);
    ex("sat_err2", -1, 1, 1, 0, 0, 5, -1, 3);
    drv(0, 32'h1000_0000, NSQ, 3'b111, 0);
    ex("sat_done", -1, 1, 0, 32'h1111_0000, 0, 5, 3'b010, 3);
    drv(0, 32'h0000_0000, IDL, 3'b101, 3'b010);
    ex("slv_err1", -1, 0, 1, 32'hCAFE_F00D, 0, 5);
    drv(0, 32'h0000_0000, IDL, 3'b111, 3'b010);
    ex("slv_err2", -1, 1, 1, 32'hCAFE_F00D, 0, 5);
    drv(0, 32'h8000_0000, NSQ, 3'b111, 0);
    ex("slv_after", -1, 1, 0, 32'h1111_0000, 0, 5);
    drv(1, 32'h0000_0000, IDL, 3'b111, 0);
    ex("rst_mid_err1", -1, 0, 1, 0, 1, 5);
    drv(0, 32'h0000_0000, IDL, 3'b111, 0);
    ex("rst_mid_after", -1, 1, 0, 0, 0, 0, -1, 0);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge hclk);
      guard++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain pending=%0d required=0",
               q.size());
    end
    @(posedge hclk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
